// File: rtl/shift_tx6.sv
// Serialiser: 6-bit word sent as start(0), d[0]..d[5] LSB first, optional even parity, stop(1).
// Optional parity bit enabled by defining SHIFT_TX6_PARITY_EN.
module shift_tx6 #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [5:0] d,
  output logic       ready,
  output logic       busy,
  output logic       tx,
  output logic       done,
  output logic [2:0] o_dbg_state
);

  // Handshake: a word transfers on any rising edge where load=1 and ready=1;
  // load is ignored whenever ready=0, and ready stays high through the done cycle.

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef SHIFT_TX6_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_idx;
  logic [5:0]      r_sh;
  logic            r_tx;
  logic            r_done;

  state_t          w_state_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [2:0]      w_idx_nxt;
  logic [5:0]      w_sh_nxt;
  logic            w_tx_nxt;
  logic            w_done_nxt;
  logic            w_bit_end;

  assign w_bit_end = (r_cnt == LAST);

  // tx is registered: each branch loads the line value for the state being entered.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_bit_end ? '0 : r_cnt + CW'(1);
    w_idx_nxt   = r_idx;
    w_sh_nxt    = r_sh;
    w_tx_nxt    = r_tx;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        w_tx_nxt  = 1'b1;
        if (load) begin
          w_state_nxt = S_START;
          w_sh_nxt    = d;
          w_idx_nxt   = 3'd0;
          w_tx_nxt    = 1'b0;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_nxt = S_DATA;
          w_idx_nxt   = 3'd0;
          w_tx_nxt    = r_sh[0];
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (r_idx == 3'd5) begin
`ifdef SHIFT_TX6_PARITY_EN
            w_state_nxt = S_PARITY;
            w_tx_nxt    = ^r_sh;
`else
            w_state_nxt = S_STOP;
            w_tx_nxt    = 1'b1;
`endif
          end else begin
            w_idx_nxt = r_idx + 3'd1;
            w_tx_nxt  = r_sh[w_idx_nxt];
          end
        end
      end
`ifdef SHIFT_TX6_PARITY_EN
      S_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = S_STOP;
          w_tx_nxt    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (w_bit_end) begin
          w_state_nxt = S_IDLE;
          w_tx_nxt    = 1'b1;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= 3'd0;
      r_sh    <= 6'd0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_sh    <= w_sh_nxt;
      r_tx    <= w_tx_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign ready       = (r_state == S_IDLE);
  assign busy        = ~ready;
  assign tx          = r_tx;
  assign done        = r_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_shift_tx6.sv
// Bench for shift_tx6: per-cycle line model (queue of expected tx values) for two
// instances (CLKS_PER_BIT=4 and 1) plus literal frame sequences.
module tb_shift_tx6;

`ifdef SHIFT_TX6_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst4, load4, ready4, busy4, tx4, done4;
  logic [5:0] d4;
  logic [2:0] st4;
  logic       rst1, load1, ready1, busy1, tx1, done1;
  logic [5:0] d1;
  logic [2:0] st1;

  shift_tx6 #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst(rst4), .load(load4), .d(d4), .ready(ready4), .busy(busy4),
    .tx(tx4), .done(done4), .o_dbg_state(st4)
  );

  shift_tx6 #(.CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst1), .load(load1), .d(d1), .ready(ready1), .busy(busy1),
    .tx(tx1), .done(done1), .o_dbg_state(st1)
  );

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Line value for bit slot b of a frame carrying v.
  function automatic logic fbit(input logic [5:0] v, input int b);
    if (b == 0) return 1'b0;
    if (b <= 6) return v[b-1];
    if (NB == 9 && b == 7) return ^v;
    return 1'b1;
  endfunction

  // Model: queue holds the tx value of every remaining frame cycle; empty = idle.
  logic m4_q[$];
  logic m1_q[$];
  logic m4_done = 1'b0;
  logic m1_done = 1'b0;

  always @(posedge clk) begin
    if (rst4) begin
      m4_q.delete();
      m4_done <= 1'b0;
    end else if (m4_q.size() == 0) begin
      m4_done <= 1'b0;
      if (load4)
        for (int b = 0; b < NB; b++)
          for (int k = 0; k < 4; k++) m4_q.push_back(fbit(d4, b));
    end else begin
      void'(m4_q.pop_front());
      m4_done <= (m4_q.size() == 0);
    end
  end

  always @(posedge clk) begin
    if (rst1) begin
      m1_q.delete();
      m1_done <= 1'b0;
    end else if (m1_q.size() == 0) begin
      m1_done <= 1'b0;
      if (load1)
        for (int b = 0; b < NB; b++) m1_q.push_back(fbit(d1, b));
    end else begin
      void'(m1_q.pop_front());
      m1_done <= (m1_q.size() == 0);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m4_tx",    tx4,    (m4_q.size() != 0) ? m4_q[0] : 1'b1);
      chk("m4_ready", ready4, (m4_q.size() == 0));
      chk("m4_busy",  busy4,  (m4_q.size() != 0));
      chk("m4_done",  done4,  m4_done);
      chk("m1_tx",    tx1,    (m1_q.size() != 0) ? m1_q[0] : 1'b1);
      chk("m1_ready", ready1, (m1_q.size() == 0));
      chk("m1_busy",  busy1,  (m1_q.size() != 0));
      chk("m1_done",  done1,  m1_done);
    end
  end

  task automatic send4(input logic [5:0] v);
    @(negedge clk); #1;
    load4 = 1'b1;
    d4    = v;
    @(posedge clk); #1;
    load4 = 1'b0;
  endtask

  // Checks every cycle of a frame against a literal bit sequence, then the done pulse.
  task automatic capture4(input logic [8:0] seq, input string nm);
    for (int i = 0; i < NB * 4; i++) begin
      @(negedge clk);
      chk({nm, "_tx"}, tx4, seq[i/4]);
      if (i == NB * 4 - 1) chk({nm, "_done_early"}, done4, 1'b0);
    end
    @(negedge clk);
    chk({nm, "_done"}, done4, 1'b1);
  endtask

  task automatic wait_done4(output int cyc, input int inj_at, input logic [5:0] inj_d);
    cyc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done4 === 1'b1) begin
        cyc = i;
        break;
      end
      if (i == inj_at) begin
        #1; load4 = 1'b1; d4 = inj_d;
      end
      if (i == inj_at + 1) begin
        #1; load4 = 1'b0;
      end
    end
    if (cyc < 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  logic [8:0] seq_a, seq_b, seq_c;
  int cyc, pulses;

  initial begin
`ifdef SHIFT_TX6_PARITY_EN
    seq_a = 9'b101011010;
    seq_b = 9'b110000010;
`else
    seq_a = 9'b011011010;
    seq_b = 9'b010000010;
`endif
    rst4 = 1'b1; load4 = 1'b0; d4 = 6'd0;
    rst1 = 1'b1; load1 = 1'b0; d1 = 6'd0;
    repeat (2) @(posedge clk);
    #1;
    rst4 = 1'b0;
    rst1 = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_tx", tx4, 1'b1);
    chk("rst_ready", ready4, 1'b1);
    chk("rst_busy", busy4, 1'b0);
    chk("rst_done", done4, 1'b0);

    // d=101101 and d=000001 frames, including parity slot when enabled
    send4(6'b101101);
    capture4(seq_a, "frame_2d");
    send4(6'b000001);
    capture4(seq_b, "frame_01");

    // load while busy is ignored; no second frame follows
    send4(6'h15);
    wait_done4(cyc, 10, 6'h3F);
    chk("busy_load_len", cyc, NB * 4);
    repeat (12) @(negedge clk);
    chk("no_second_ready", ready4, 1'b1);
    chk("no_second_tx", tx4, 1'b1);

    // load held high: second word accepted in the done cycle
    @(negedge clk); #1;
    load4 = 1'b1; d4 = 6'h15;
    @(posedge clk); #1;
    d4 = 6'h2A;
    wait_done4(cyc, -10, 6'h00);
    chk("b2b_len1", cyc, NB * 4);
    chk("b2b_ready_done", ready4, 1'b1);
    @(posedge clk); #1;
    load4 = 1'b0;
    @(negedge clk);
    chk("b2b_start_tx", tx4, 1'b0);
    chk("b2b_start_busy", busy4, 1'b1);
    wait_done4(cyc, -10, 6'h00);
    chk("b2b_len2", cyc, NB * 4 - 1);

    // reset during data bit 3 aborts the frame
    send4(6'b101101);
    repeat (17) @(negedge clk);
    #1; rst4 = 1'b1;
    @(posedge clk); #1;
    rst4 = 1'b0;
    @(negedge clk);
    chk("abort_tx", tx4, 1'b1);
    chk("abort_ready", ready4, 1'b1);
    chk("abort_busy", busy4, 1'b0);
    chk("abort_done", done4, 1'b0);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done4 !== 1'b0) pulses++;
    end
    chk("abort_no_done", pulses, 0);
    send4(6'b101101);
    capture4(seq_a, "after_rst");

    // single clock per bit
    @(negedge clk); #1;
    load1 = 1'b1; d1 = 6'h01;
    @(posedge clk); #1;
    load1 = 1'b0;
    seq_c = seq_b;
    for (int i = 0; i < NB; i++) begin
      @(negedge clk);
      chk("cpb1_tx", tx1, seq_c[i]);
      chk("cpb1_busy", busy1, 1'b1);
    end
    @(negedge clk);
    chk("cpb1_done", done1, 1'b1);

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
